id_ex_fwd_reg: RTL and testbench
================================

Name: id_ex_fwd_reg

Overview:
- ID/EX pipeline register of the 5-stage core.
- Also pre-computes, one stage early, the 2-bit forwarding selects consumed by the EX-stage 3-input operand muxes.
- Detects load-use hazards and inserts a bubble itself.
- Sits between decode/register-file read and the EX-stage forwarding muxes and ALU.

Parameters:
XLEN, 32, data/address width
CTRL_W, 16, width of opaque EX/MEM/WB control bundle passed through

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
stall  input  1  global hold (e.g. memory wait); freeze all registers
flush  input  1  branch/jump redirect; load a bubble
id_valid  input  1  ID holds a real instruction
id_pc  input  XLEN  instruction PC
id_rs1, id_rs2  input  5  source register indices
id_use_rs1, id_use_rs2  input  1  instruction actually reads rs1/rs2
id_rd  input  5  destination index
id_rf_we  input  1  writes register file
id_mem_rd  input  1  is a load
id_mem_we  input  1  is a store
id_rs1_data, id_rs2_data  input  XLEN  register-file read data
id_imm  input  XLEN  immediate
id_ctrl  input  CTRL_W  remaining control
mem_rd  input  5  rd currently in MEM stage
mem_rf_we  input  1  MEM-stage instruction writes register file
ex_valid, ex_rf_we, ex_mem_rd, ex_mem_we  output  1  registered copies
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN  registered copies
ex_rd  output  5  registered copy
ex_ctrl  output  CTRL_W  registered copy
ex_fwd_a_sel, ex_fwd_b_sel  output  2  forwarding selects: 0 = register-file data, 1 = WB result, 2 = MEM-stage ALU result
load_use_stall  output  1  combinational; IF/ID must hold this cycle

Behaviour:
- Reset (rstn low, asynchronous): all outputs/registers 0. An all-zero state is a bubble.
- Per-edge priority: flush > stall > load_use_stall > normal load.
  - flush: bubble.
  - stall: hold everything, including selects.
  - load_use_stall: bubble.
  - normal: capture all id_* inputs plus computed selects; latency 1 cycle.
- Bubble definition:
  - ex_valid = ex_rf_we = ex_mem_rd = ex_mem_we = 0.
  - ex_fwd_*_sel = 0.
  - ex_rd = 0.
  - Datapath fields may be don't-care; the implementation drives them 0.
- load_use_stall = id_valid & ex_valid & ex_mem_rd & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
  - Not gated by stall or flush; the upstream controller applies the same priority.
- Select for operand A, computed at ID for use next cycle (B identical with rs2):
  - 2 if id_use_rs1 & ex_valid & ex_rf_we & !ex_mem_rd & ex_rd != 0 & ex_rd == id_rs1. The current EX instruction will be in MEM next cycle.
  - else 1 if mem_rf_we & mem_rd != 0 & mem_rd == id_rs1. The current MEM instruction will be in WB next cycle.
  - else 0.
- Boundary rules:
  - Closest producer wins when both match.
  - Register x0 never forwards.
  - Same-cycle WB→ID is not forwarded: the register file is write-through.
- After a load-use bubble, the load is in MEM, so the dependent instruction gets select 1 (load data from WB).
- id_valid = 0 captures as a bubble: ex_valid = 0 and selects still computed. This is harmless, as all write enables are captured as 0.
- Reset asserted mid-operation clears immediately, regardless of stall.

Decomposition:
- Shared package holds:
  - FWD_RF = 2'd0, FWD_WB = 2'd1, FWD_MEM = 2'd2.
  - Default CTRL_W.
  - Bubble constant for the control bundle.
- One combinational sub-module, fwd_sel_calc, computes a single select from (rs, use, ex_*, mem_*). It is instantiated twice (A, B).
- Load-use logic and registers stay in the top.

Test Plan:
- Reset: rstn=0 mid-stream with stall=1 → all outputs 0 immediately. First edge after release with id_valid=1, id_pc=0x100 → ex_pc=0x100, ex_valid=1.
- EX→MEM forward: ADD x5 in EX (ex_rf_we=1); ID reads rs1=5 → after edge, ex_fwd_a_sel=2, ex_fwd_b_sel=0. Additionally, with mem_rd=5 matching simultaneously → select remains 2.
- MEM→WB forward: mem_rd=7, mem_rf_we=1; ID rs2=7, use_rs2=1 → ex_fwd_b_sel=1. Same with rs2=0 and mem_rd=0 → 0.
- Load-use: LW x3 in EX; ID rs1=3 → load_use_stall=1 and next edge gives bubble (ex_valid=0). Following cycle, with mem_rd=3 → ex_fwd_a_sel=1 and load_use_stall=0.
- Stall/flush: stall=1 for 3 cycles → ex_* and selects unchanged. flush=1 together with stall=1 → bubble. flush together with load_use_stall → bubble, ex_rd=0.
- Unused operand: LUI-style instruction with id_use_rs1=0 and ex_rd==id_rs1 on a load → load_use_stall=0, select 0.

Source files
------------

// File: rtl/id_ex_fwd_reg_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_fwd_reg_pkg
//
// Shared definitions for the ID/EX pipeline register and its forwarding-select
// logic:
//   - fwd_sel_e    : encoding of the EX-stage 3-input operand mux select
//   - CTRL_W_DEF   : default width of the opaque EX/MEM/WB control bundle
//   - XLEN_DEF     : default data/address width
//   - CTRL_BUBBLE  : value loaded into the control bundle on a bubble
//   - rd_hit()     : "producer rd matches consumer rs and is not x0"
// -----------------------------------------------------------------------------
package id_ex_fwd_reg_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int CTRL_W_DEF = 16;

    // Operand mux select: register-file data, WB-stage result, MEM-stage ALU result.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

    // x0 is hardwired to zero, so a write to it never produces a forwardable value.
    function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_fwd_reg_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel_calc
//
// Combinational forwarding-select for one source operand. Evaluated in ID so
// that the select is registered alongside the operand and is ready at the start
// of EX.
//
// Ports:
//   rs_i         source register index read by the ID instruction
//   use_i        ID instruction actually reads rs_i
//   ex_valid_i   EX stage holds a real instruction
//   ex_rf_we_i   EX instruction writes the register file
//   ex_mem_rd_i  EX instruction is a load (its data is not ready in MEM)
//   ex_rd_i      EX destination index
//   mem_rf_we_i  MEM instruction writes the register file
//   mem_rd_i     MEM destination index
//   sel_o        FWD_MEM / FWD_WB / FWD_RF
// -----------------------------------------------------------------------------
module fwd_sel_calc
    import id_ex_fwd_reg_pkg::*;
(
    input  logic [4:0] rs_i,
    input  logic       use_i,
    input  logic       ex_valid_i,
    input  logic       ex_rf_we_i,
    input  logic       ex_mem_rd_i,
    input  logic [4:0] ex_rd_i,
    input  logic       mem_rf_we_i,
    input  logic [4:0] mem_rd_i,
    output logic [1:0] sel_o
);

    logic ex_hit;
    logic mem_hit;

    // Today's EX instruction is in MEM next cycle; a load has no ALU result
    // to forward there, which is exactly the load-use case handled by a bubble.
    assign ex_hit  = use_i && ex_valid_i && ex_rf_we_i && !ex_mem_rd_i
                     && rd_hit(ex_rd_i, rs_i);

    // Today's MEM instruction is in WB next cycle. A same-cycle WB producer is
    // not considered: the register file is write-through.
    assign mem_hit = mem_rf_we_i && rd_hit(mem_rd_i, rs_i);

    // Closest producer wins.
    always_comb begin
        sel_o = FWD_RF;
        if (ex_hit) begin
            sel_o = FWD_MEM;
        end else if (mem_hit) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_fwd_reg.sv
// -----------------------------------------------------------------------------
// id_ex_fwd_reg
//
// ID/EX pipeline register of the 5-stage core. Besides registering the decoded
// instruction it pre-computes the EX-stage operand forwarding selects one stage
// early and detects load-use hazards, inserting the bubble itself.
//
// Per-edge priority: flush > stall > load_use_stall > normal load.
//   flush          -> bubble
//   stall          -> hold everything (including selects)
//   load_use_stall -> bubble
//   otherwise      -> capture id_* and computed selects
// A bubble is all-zero, which is also the reset state.
//
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   stall, flush                      global hold, branch/jump redirect
//   id_*                              decoded instruction and operands from ID
//   mem_rd, mem_rf_we                 destination of the MEM-stage instruction
//   ex_*                              registered instruction for EX
//   ex_fwd_a_sel, ex_fwd_b_sel        operand mux selects (fwd_sel_e encoding)
//   load_use_stall                    combinational; IF/ID must hold this cycle
// -----------------------------------------------------------------------------
module id_ex_fwd_reg
    import id_ex_fwd_reg_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_rf_we,
    input  logic              id_mem_rd,
    input  logic              id_mem_we,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        mem_rd,
    input  logic              mem_rf_we,
    output logic              ex_valid,
    output logic              ex_rf_we,
    output logic              ex_mem_rd,
    output logic              ex_mem_we,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        ex_fwd_a_sel,
    output logic [1:0]        ex_fwd_b_sel,
    output logic              load_use_stall
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              ex_valid_q,  ex_valid_d;
    logic              ex_rf_we_q,  ex_rf_we_d;
    logic              ex_mem_rd_q, ex_mem_rd_d;
    logic              ex_mem_we_q, ex_mem_we_d;
    logic [XLEN-1:0]   ex_pc_q,     ex_pc_d;
    logic [XLEN-1:0]   ex_rs1_q,    ex_rs1_d;
    logic [XLEN-1:0]   ex_rs2_q,    ex_rs2_d;
    logic [XLEN-1:0]   ex_imm_q,    ex_imm_d;
    logic [4:0]        ex_rd_q,     ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;
    logic [1:0]        fwd_a_q,     fwd_a_d;
    logic [1:0]        fwd_b_q,     fwd_b_d;

    logic [1:0]        fwd_a_calc;
    logic [1:0]        fwd_b_calc;
    logic              lu_rs1;
    logic              lu_rs2;
    logic              load_use;
    logic              take_bubble;
    logic              take_load;

    // -------------------------------------------------------------------------
    // Forwarding selects for the instruction currently in ID
    // -------------------------------------------------------------------------
    fwd_sel_calc u_fwd_a (
        .rs_i        (id_rs1),
        .use_i       (id_use_rs1),
        .ex_valid_i  (ex_valid_q),
        .ex_rf_we_i  (ex_rf_we_q),
        .ex_mem_rd_i (ex_mem_rd_q),
        .ex_rd_i     (ex_rd_q),
        .mem_rf_we_i (mem_rf_we),
        .mem_rd_i    (mem_rd),
        .sel_o       (fwd_a_calc)
    );

    fwd_sel_calc u_fwd_b (
        .rs_i        (id_rs2),
        .use_i       (id_use_rs2),
        .ex_valid_i  (ex_valid_q),
        .ex_rf_we_i  (ex_rf_we_q),
        .ex_mem_rd_i (ex_mem_rd_q),
        .ex_rd_i     (ex_rd_q),
        .mem_rf_we_i (mem_rf_we),
        .mem_rd_i    (mem_rd),
        .sel_o       (fwd_b_calc)
    );

    // -------------------------------------------------------------------------
    // Load-use hazard: a load in EX whose result the ID instruction needs.
    // Deliberately not gated by stall/flush; upstream applies the same priority.
    // -------------------------------------------------------------------------
    assign lu_rs1   = id_use_rs1 && rd_hit(ex_rd_q, id_rs1);
    assign lu_rs2   = id_use_rs2 && rd_hit(ex_rd_q, id_rs2);
    assign load_use = id_valid && ex_valid_q && ex_mem_rd_q && (lu_rs1 || lu_rs2);

    assign take_bubble = flush || (!stall && load_use);
    assign take_load   = !flush && !stall && !load_use;

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_rf_we_d  = ex_rf_we_q;
        ex_mem_rd_d = ex_mem_rd_q;
        ex_mem_we_d = ex_mem_we_q;
        ex_pc_d     = ex_pc_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_imm_d    = ex_imm_q;
        ex_rd_d     = ex_rd_q;
        ex_ctrl_d   = ex_ctrl_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;

        if (take_bubble) begin
            ex_valid_d  = 1'b0;
            ex_rf_we_d  = 1'b0;
            ex_mem_rd_d = 1'b0;
            ex_mem_we_d = 1'b0;
            ex_pc_d     = '0;
            ex_rs1_d    = '0;
            ex_rs2_d    = '0;
            ex_imm_d    = '0;
            ex_rd_d     = 5'd0;
            ex_ctrl_d   = CTRL_W'(CTRL_BUBBLE);
            fwd_a_d     = FWD_RF;
            fwd_b_d     = FWD_RF;
        end else if (take_load) begin
            // An invalid ID slot enters EX as a bubble: every side effect and
            // the destination are masked, the selects are still captured.
            ex_valid_d  = id_valid;
            ex_rf_we_d  = id_valid && id_rf_we;
            ex_mem_rd_d = id_valid && id_mem_rd;
            ex_mem_we_d = id_valid && id_mem_we;
            ex_rd_d     = id_valid ? id_rd : 5'd0;
            ex_pc_d     = id_pc;
            ex_rs1_d    = id_rs1_data;
            ex_rs2_d    = id_rs2_data;
            ex_imm_d    = id_imm;
            ex_ctrl_d   = id_ctrl;
            fwd_a_d     = fwd_a_calc;
            fwd_b_d     = fwd_b_calc;
        end
    end

    // -------------------------------------------------------------------------
    // Registers (reset clears immediately, regardless of stall)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid_q  <= 1'b0;
            ex_rf_we_q  <= 1'b0;
            ex_mem_rd_q <= 1'b0;
            ex_mem_we_q <= 1'b0;
            ex_pc_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_imm_q    <= '0;
            ex_rd_q     <= 5'd0;
            ex_ctrl_q   <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rf_we_q  <= ex_rf_we_d;
            ex_mem_rd_q <= ex_mem_rd_d;
            ex_mem_we_q <= ex_mem_we_d;
            ex_pc_q     <= ex_pc_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_imm_q    <= ex_imm_d;
            ex_rd_q     <= ex_rd_d;
            ex_ctrl_q   <= ex_ctrl_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_rf_we       = ex_rf_we_q;
    assign ex_mem_rd      = ex_mem_rd_q;
    assign ex_mem_we      = ex_mem_we_q;
    assign ex_pc          = ex_pc_q;
    assign ex_rs1_data    = ex_rs1_q;
    assign ex_rs2_data    = ex_rs2_q;
    assign ex_imm         = ex_imm_q;
    assign ex_rd          = ex_rd_q;
    assign ex_ctrl        = ex_ctrl_q;
    assign ex_fwd_a_sel   = fwd_a_q;
    assign ex_fwd_b_sel   = fwd_b_q;
    assign load_use_stall = load_use;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
module tb_id_ex_fwd_reg;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall, flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic [4:0]  id_rd;
    logic        id_rf_we, id_mem_rd, id_mem_we;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [15:0] id_ctrl;
    logic [4:0]  mem_rd;
    logic        mem_rf_we;
    logic        ex_valid, ex_rf_we, ex_mem_rd, ex_mem_we;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl;
    logic [1:0]  ex_fwd_a_sel, ex_fwd_b_sel;
    logic        load_use_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_fwd_reg dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_rf_we(id_rf_we), .id_mem_rd(id_mem_rd), .id_mem_we(id_mem_we),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
        .ex_valid(ex_valid), .ex_rf_we(ex_rf_we), .ex_mem_rd(ex_mem_rd),
        .ex_mem_we(ex_mem_we), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_fwd_a_sel(ex_fwd_a_sel),
        .ex_fwd_b_sel(ex_fwd_b_sel), .load_use_stall(load_use_stall)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the EX slot as one record
    // ------------------------------------------------------------------
    typedef struct {
        logic        valid, rf_we, mrd, mwe;
        logic [4:0]  rd;
        logic [31:0] pc, a, b, imm;
        logic [15:0] ctrl;
        logic [1:0]  sa, sb;
    } slot_t;

    slot_t m;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.rf_we = 0; s.mrd = 0; s.mwe = 0; s.rd = 0;
        s.pc = 0; s.a = 0; s.b = 0; s.imm = 0; s.ctrl = 0; s.sa = 0; s.sb = 0;
        return s;
    endfunction

    // Where will the newest value of register r be next cycle?
    function automatic logic [1:0] where_is(input logic needed, input logic [4:0] r);
        if (r == 0) return 2'd0;
        if (needed && m.valid && m.rf_we && !m.mrd && m.rd == r) return 2'd2;
        if (mem_rf_we && mem_rd == r) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic hazard();
        logic needs_load;
        needs_load = m.valid && m.mrd && m.rd != 0 &&
                     ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd));
        return id_valid && needs_load;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m <= empty_slot();
        end else if (flush) begin
            m <= empty_slot();
        end else if (stall) begin
            m <= m;
        end else if (hazard()) begin
            m <= empty_slot();
        end else begin
            slot_t n;
            n.valid = id_valid;
            n.rf_we = id_valid & id_rf_we;
            n.mrd   = id_valid & id_mem_rd;
            n.mwe   = id_valid & id_mem_we;
            n.rd    = id_valid ? id_rd : 5'd0;
            n.pc = id_pc; n.a = id_rs1_data; n.b = id_rs2_data; n.imm = id_imm; n.ctrl = id_ctrl;
            n.sa = where_is(id_use_rs1, id_rs1);
            n.sb = where_is(id_use_rs2, id_rs2);
            m <= n;
        end
    end

    // Compare process: every cycle out of reset, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            chk("cmp_valid", ex_valid, m.valid);
            chk("cmp_rf_we", ex_rf_we, m.rf_we);
            chk("cmp_mem_rd", ex_mem_rd, m.mrd);
            chk("cmp_mem_we", ex_mem_we, m.mwe);
            chk("cmp_rd", ex_rd, m.rd);
            chk("cmp_pc", ex_pc, m.pc);
            chk("cmp_rs1_data", ex_rs1_data, m.a);
            chk("cmp_rs2_data", ex_rs2_data, m.b);
            chk("cmp_imm", ex_imm, m.imm);
            chk("cmp_ctrl", ex_ctrl, m.ctrl);
            chk("cmp_sel_a", ex_fwd_a_sel, m.sa);
            chk("cmp_sel_b", ex_fwd_b_sel, m.sb);
            chk("cmp_load_use", load_use_stall, hazard());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; id_valid = 0; id_pc = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0;
        id_rf_we = 0; id_mem_rd = 0; id_mem_we = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_ctrl = 0;
        mem_rd = 0; mem_rf_we = 0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                         input logic mrd, input logic mwe,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        id_valid = 1; id_pc = pc; id_rd = rd; id_rf_we = we; id_mem_rd = mrd; id_mem_we = mwe;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = pc ^ 32'h5A5A_0000;
        id_imm      = pc + 32'd1;
        id_ctrl     = pc[15:0] ^ 16'hBEEF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_sel_a", ex_fwd_a_sel, 0);
        chk("rst_lu", load_use_stall, 0);

        // Load something, then async reset mid-stream while stalled
        rstn = 1;
        instr(32'h40, 5'd1, 1, 0, 0, 5'd0, 0, 5'd0, 0);
        tick();
        chk("pre_rst_pc", ex_pc, 32'h40);
        stall = 1;
        rstn  = 0;
        #1;
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_pc", ex_pc, 0);
        chk("async_rst_rd", ex_rd, 0);
        chk("async_rst_we", ex_rf_we, 0);
        tick();
        rstn  = 1;
        stall = 0;
        instr(32'h100, 5'd5, 1, 0, 0, 5'd1, 1, 5'd2, 1);
        tick();
        chk("first_pc", ex_pc, 32'h100);
        chk("first_valid", ex_valid, 1);
        chk("first_rd", ex_rd, 5);

        // EX->MEM forward on operand A
        instr(32'h104, 5'd5, 1, 0, 0, 5'd5, 1, 5'd6, 1);
        tick();
        chk("exmem_sel_a", ex_fwd_a_sel, 2);
        chk("exmem_sel_b", ex_fwd_b_sel, 0);

        // Both EX and MEM produce x5: EX (closest) wins
        instr(32'h108, 5'd9, 1, 0, 0, 5'd5, 1, 5'd6, 1);
        mem_rd = 5'd5; mem_rf_we = 1;
        tick();
        chk("closest_sel_a", ex_fwd_a_sel, 2);

        // MEM->WB forward on operand B
        instr(32'h10C, 5'd10, 1, 0, 0, 5'd8, 1, 5'd7, 1);
        mem_rd = 5'd7; mem_rf_we = 1;
        tick();
        chk("memwb_sel_b", ex_fwd_b_sel, 1);
        chk("memwb_sel_a", ex_fwd_a_sel, 0);

        // x0 never forwards (store instruction)
        instr(32'h110, 5'd0, 0, 0, 1, 5'd8, 1, 5'd0, 1);
        mem_rd = 5'd0; mem_rf_we = 1;
        tick();
        chk("x0_sel_b", ex_fwd_b_sel, 0);
        chk("store_mem_we", ex_mem_we, 1);

        // Load-use: LW x3 then a consumer of x3
        instr(32'h200, 5'd3, 1, 1, 0, 5'd0, 0, 5'd0, 0);
        mem_rd = 0; mem_rf_we = 0;
        tick();
        instr(32'h204, 5'd4, 1, 0, 0, 5'd3, 1, 5'd2, 1);
        #1;
        chk("lu_asserted", load_use_stall, 1);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_rd", ex_rd, 0);
        chk("lu_bubble_sel_a", ex_fwd_a_sel, 0);
        mem_rd = 5'd3; mem_rf_we = 1;
        #1;
        chk("lu_released", load_use_stall, 0);
        tick();
        chk("after_lu_valid", ex_valid, 1);
        chk("after_lu_pc", ex_pc, 32'h204);
        chk("after_lu_sel_a", ex_fwd_a_sel, 1);

        // Stall 3 cycles: nothing changes, even though ID would select 2
        instr(32'h208, 5'd12, 1, 0, 0, 5'd4, 1, 5'd0, 0);
        mem_rd = 0; mem_rf_we = 0;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", ex_pc, 32'h204);
            chk("stall_sel_a", ex_fwd_a_sel, 1);
        end
        stall = 0;
        tick();
        chk("unstall_pc", ex_pc, 32'h208);
        chk("unstall_sel_a", ex_fwd_a_sel, 2);

        // flush beats stall
        instr(32'h20C, 5'd13, 1, 0, 0, 5'd12, 1, 5'd0, 0);
        stall = 1; flush = 1;
        tick();
        chk("flush_stall_valid", ex_valid, 0);
        chk("flush_stall_rd", ex_rd, 0);
        chk("flush_stall_we", ex_rf_we, 0);
        stall = 0; flush = 0;

        // flush together with a load-use hazard
        instr(32'h300, 5'd11, 1, 1, 0, 5'd0, 0, 5'd0, 0);
        tick();
        instr(32'h304, 5'd13, 1, 0, 0, 5'd1, 1, 5'd11, 1);
        #1;
        chk("lu_b_asserted", load_use_stall, 1);
        flush = 1;
        tick();
        chk("flush_lu_valid", ex_valid, 0);
        chk("flush_lu_rd", ex_rd, 0);
        flush = 0;

        // Unused operand behind a load: no hazard, select 0
        instr(32'h400, 5'd12, 1, 1, 0, 5'd0, 0, 5'd0, 0);
        tick();
        instr(32'h404, 5'd12, 1, 0, 0, 5'd12, 0, 5'd0, 0);
        #1;
        chk("unused_lu", load_use_stall, 0);
        tick();
        chk("unused_sel_a", ex_fwd_a_sel, 0);
        chk("unused_valid", ex_valid, 1);
        chk("unused_pc", ex_pc, 32'h404);

        // Invalid ID slot enters EX as a bubble
        instr(32'h408, 5'd7, 1, 0, 1, 5'd0, 0, 5'd0, 0);
        id_valid = 0;
        tick();
        chk("inval_valid", ex_valid, 0);
        chk("inval_we", ex_rf_we, 0);
        chk("inval_mem_we", ex_mem_we, 0);

        idle();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
